// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave front end.
package i2c_pkg;

    typedef enum logic {IDLE, BUSY} bus_state_e;

    localparam int I2C_FRAME_BITS = 9;   // 8 data bits + ACK
    localparam int I2C_IDX_W      = 4;   // wide enough for frame positions 0..8

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus glitch filter for one open-drain I2C line.
// The filtered level only follows the synchronised level after FILT_LEN
// consecutive samples disagree with it, so shorter glitches never appear.
// Everything resets to 1, the idle level of a pulled-up bus line.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic nRst,
    input  logic raw_i,
    output logic filt_o
);

    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Count consecutive disagreeing samples; adopt the new level after FILT_LEN of them.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q  <= '0;
            filt_o <= 1'b1;
        end else if (synced == filt_o) begin
            cnt_q  <= '0;
        end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
            cnt_q  <= '0;
            filt_o <= synced;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: filters SCL/SDA, detects SCL edges, START, repeated START
// and STOP, tracks bus ownership and reports each sampled bit with its
// position in the 9-bit frame. All pulse outputs are registered.
module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 scl_f,
    output logic                 sda_f,
    output logic                 scl_rise,
    output logic                 scl_fall,
    output logic                 start,
    output logic                 rep_start,
    output logic                 stop,
    output logic                 bus_busy,
    output logic                 bit_valid,
    output logic                 bit_data,
    output logic [I2C_IDX_W-1:0] bit_idx
);

    localparam logic [I2C_IDX_W-1:0] LAST_IDX = I2C_IDX_W'(I2C_FRAME_BITS - 1);

    bus_state_e           state_q, state_d;
    logic                 scl_p, sda_p;
    logic [I2C_IDX_W-1:0] idx_q, idx_d;

    logic scl_rise_c, scl_fall_c, start_c, stop_c;
    logic start_d, rep_start_d, stop_d, bit_valid_d, bit_data_d;
    logic [I2C_IDX_W-1:0] bit_idx_d;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk    (clk),
        .nRst   (nRst),
        .raw_i  (scl_i),
        .filt_o (scl_f)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk    (clk),
        .nRst   (nRst),
        .raw_i  (sda_i),
        .filt_o (sda_f)
    );

    // Bus conditions require SCL high in both the previous and current cycle,
    // so a simultaneous SCL/SDA change is treated as a plain SCL edge.
    assign scl_rise_c =  scl_f & ~scl_p;
    assign scl_fall_c = ~scl_f &  scl_p;
    assign start_c    =  scl_f &  scl_p &  sda_p & ~sda_f;
    assign stop_c     =  scl_f &  scl_p & ~sda_p &  sda_f;

    assign bus_busy = (state_q == BUSY);

    // Remember last cycle's filtered levels for edge detection.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    // Next-state, bit index and next pulse values from the detected conditions.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        start_d     = 1'b0;
        rep_start_d = 1'b0;
        stop_d      = 1'b0;
        bit_valid_d = 1'b0;
        bit_data_d  = bit_data;
        bit_idx_d   = bit_idx;
        if (start_c) begin
            start_d     = 1'b1;
            rep_start_d = (state_q == BUSY);
            state_d     = BUSY;
            idx_d       = '0;
            bit_idx_d   = '0;
        end else if (stop_c) begin
            stop_d    = 1'b1;
            state_d   = IDLE;
            idx_d     = '0;
            bit_idx_d = '0;
        end else if (scl_rise_c && state_q == BUSY) begin
            bit_valid_d = 1'b1;
            bit_data_d  = sda_f;
            bit_idx_d   = idx_q;
            idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + I2C_IDX_W'(1);
        end
    end

    // Register FSM state, frame counter and all pulse/bit outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start     <= 1'b0;
            rep_start <= 1'b0;
            stop      <= 1'b0;
            bit_valid <= 1'b0;
            bit_data  <= 1'b0;
            bit_idx   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            scl_rise  <= scl_rise_c;
            scl_fall  <= scl_fall_c;
            start     <= start_d;
            rep_start <= rep_start_d;
            stop      <= stop_d;
            bit_valid <= bit_valid_d;
            bit_data  <= bit_data_d;
            bit_idx   <= bit_idx_d;
        end
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed testbench for i2c_bus_monitor at default parameters.
module tb_i2c_bus_monitor;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       scl_i = 1'b1;
    logic       sda_i = 1'b1;
    logic       scl_f, sda_f, scl_rise, scl_fall, start, rep_start, stop;
    logic       bus_busy, bit_valid, bit_data;
    logic [3:0] bit_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Event capture, sampled mid-cycle.
    int         start_cnt = 0, rep_cnt = 0, stop_cnt = 0, rise_cnt = 0, fall_cnt = 0;
    logic       bv_data[$];
    logic [3:0] bv_idx[$];

    i2c_bus_monitor dut (
        .clk       (clk),
        .nRst      (nRst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_f     (scl_f),
        .sda_f     (sda_f),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start     (start),
        .rep_start (rep_start),
        .stop      (stop),
        .bus_busy  (bus_busy),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_idx   (bit_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start)     start_cnt <= start_cnt + 1;
        if (rep_start) rep_cnt   <= rep_cnt + 1;
        if (stop)      stop_cnt  <= stop_cnt + 1;
        if (scl_rise)  rise_cnt  <= rise_cnt + 1;
        if (scl_fall)  fall_cnt  <= fall_cnt + 1;
        if (bit_valid) begin
            bv_data.push_back(bit_data);
            bv_idx.push_back(bit_idx);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, ending just after the active edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        scl_i = 1'b0; wait_clks(8);
        sda_i = b;    wait_clks(8);
        scl_i = 1'b1; wait_clks(8);
    endtask

    task automatic send_stop();
        scl_i = 1'b0; wait_clks(8);
        sda_i = 1'b0; wait_clks(8);
        scl_i = 1'b1; wait_clks(8);
        sda_i = 1'b1; wait_clks(10);
    endtask

    initial begin
        int         sb, pb, rb, fb, qb;
        logic [7:0] byte_v;
        logic [8:0] exp_bits;

        // 1: reset state
        wait_clks(3);
        @(negedge clk);
        check("rst_scl_f", scl_f, 1'b1);
        check("rst_sda_f", sda_f, 1'b1);
        check("rst_busy", bus_busy, 1'b0);
        check("rst_pulses", {scl_rise, scl_fall, start, rep_start, stop, bit_valid}, 6'b0);
        check("rst_bit_idx", bit_idx, 4'd0);
        @(posedge clk); #1;
        nRst = 1'b1;
        wait_clks(10);

        // 2: 2-clk SDA glitch is ignored; 3-clk low gives START then STOP
        sb = start_cnt; pb = stop_cnt;
        sda_i = 1'b0; wait_clks(2);
        sda_i = 1'b1; wait_clks(12);
        check("glitch2_sda_f", sda_f, 1'b1);
        check("glitch2_start", start_cnt - sb, 0);
        check("glitch2_stop", stop_cnt - pb, 0);
        sda_i = 1'b0; wait_clks(3);
        sda_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("glitch3_busy_high", bus_busy, 1'b1);
        wait_clks(10);
        check("glitch3_start", start_cnt - sb, 1);
        check("glitch3_stop", stop_cnt - pb, 1);
        check("glitch3_busy_low", bus_busy, 1'b0);

        // 3: START latency is 6 clocks, pulse lasts 1 clock
        sda_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("lat_n5_start", start, 1'b0);
        check("lat_n5_busy", bus_busy, 1'b0);
        @(negedge clk);
        check("lat_n6_start", start, 1'b1);
        check("lat_n6_rep", rep_start, 1'b0);
        check("lat_n6_busy", bus_busy, 1'b1);
        @(negedge clk);
        check("lat_n7_start", start, 1'b0);
        check("lat_n7_busy", bus_busy, 1'b1);
        @(posedge clk); #1;
        wait_clks(5);

        // 4: byte 0xA5 plus ACK=0
        qb = bv_data.size();
        byte_v = 8'hA5;
        exp_bits = {byte_v, 1'b0};
        for (int i = 0; i < 9; i++) send_bit(exp_bits[8-i]);
        check("byte_bit_count", bv_data.size() - qb, 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("byte_data_%0d", i), bv_data[qb+i], exp_bits[8-i]);
            check($sformatf("byte_idx_%0d", i), bv_idx[qb+i], i[3:0]);
        end

        // 5: index wraps, repeated START resets it, then STOP
        send_bit(1'b1);
        send_bit(1'b1);
        check("wrap_idx0", bv_idx[qb+9], 4'd0);
        check("wrap_idx1", bv_idx[qb+10], 4'd1);
        sb = start_cnt; rb = rep_cnt; pb = stop_cnt;
        scl_i = 1'b0; wait_clks(8);
        sda_i = 1'b1; wait_clks(8);
        scl_i = 1'b1; wait_clks(8);
        sda_i = 1'b0; wait_clks(10);
        check("rs_start", start_cnt - sb, 1);
        check("rs_rep", rep_cnt - rb, 1);
        check("rs_busy", bus_busy, 1'b1);
        check("rs_bit_idx_clear", bit_idx, 4'd0);
        send_bit(1'b0);
        check("rs_next_idx", bv_idx[bv_idx.size()-1], 4'd0);
        check("rs_next_data", bv_data[bv_data.size()-1], 1'b0);
        send_stop();
        check("stop_pulse", stop_cnt - pb, 1);
        check("stop_busy", bus_busy, 1'b0);
        check("stop_no_rep", rep_cnt - rb, 1);

        // 6: reset mid-byte, SCL activity without START gives no bits
        sda_i = 1'b0; wait_clks(10);
        check("t6_busy", bus_busy, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("t6_pre_idx", bit_idx, 4'd2);
        nRst = 1'b0;
        wait_clks(1);
        check("t6_rst_busy", bus_busy, 1'b0);
        check("t6_rst_idx", bit_idx, 4'd0);
        wait_clks(1);
        nRst = 1'b1;
        wait_clks(10);
        sb = start_cnt; rb = rise_cnt; fb = fall_cnt; qb = bv_data.size();
        for (int i = 0; i < 5; i++) begin
            scl_i = 1'b0; wait_clks(8);
            scl_i = 1'b1; wait_clks(8);
        end
        check("t6_rises", rise_cnt - rb, 5);
        check("t6_falls", fall_cnt - fb, 5);
        check("t6_no_bits", bv_data.size() - qb, 0);
        check("t6_no_start", start_cnt - sb, 0);
        check("t6_idle", bus_busy, 1'b0);
        sda_i = 1'b0; wait_clks(10);
        check("t6_restart_busy", bus_busy, 1'b1);
        send_bit(1'b1);
        check("t6_restart_bits", bv_data.size() - qb, 1);
        check("t6_restart_idx", bv_idx[bv_idx.size()-1], 4'd0);
        send_stop();
        check("t6_final_idle", bus_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
